// File: rtl/enemy_spawner.sv
// Enemy spawn controller. It times spawns in frame ticks, picks a lane from a
// 16-bit LFSR, shortens the spawn interval as play goes on, and locks up in
// HALT after a collision until reset.
module enemy_spawner #(
  parameter int          LANE_COUNT     = 4,
  parameter int          LANE0_X        = 129,
  parameter int          LANE_PITCH     = 80,
  parameter int          SPAWN_Y        = 610,
  parameter int          SPAWN_INTERVAL = 120,
  parameter int          MIN_INTERVAL   = 30,
  parameter int          RAMP_EVERY     = 8,
  parameter int          RAMP_STEP      = 10,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       logic_tick,
  input  logic       run,
  input  logic       collision,
  output logic       enable,
  output logic [9:0] offset_x,
  output logic [9:0] offset_y,
  output logic [1:0] lane,
  output logic [7:0] spawn_total,
  output logic       halted
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, WAIT, SPAWN, HALT} state_t;

  state_t      state, state_d;
  logic [15:0] tick_cnt;
  logic [15:0] interval;
  logic [7:0]  spawn_cnt;
  logic [15:0] lfsr, lfsr_nxt;
  logic        first_spawn;
  logic        tick_adv;   // tick counted in WAIT this cycle
  logic        spawn_go;   // this edge enters SPAWN
  logic        go_idle;    // this edge drops back to IDLE
  logic [1:0]  raw, raw_m, lane_sel;

  // Next LFSR value; lane is picked from the value that is current once SPAWN is entered.
  always_comb begin
    lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Lane selection: fold out-of-range raw values, then avoid repeating the last lane.
  always_comb begin
    raw   = lfsr_nxt[1:0];
    raw_m = raw;
    if (int'(raw) >= LANE_COUNT) raw_m = raw - 2'(LANE_COUNT);
    lane_sel = raw_m;
    if (!first_spawn && raw_m == lane)
      lane_sel = (int'(lane) + 1 >= LANE_COUNT) ? 2'd0 : lane + 2'd1;
  end

  // Next-state logic; collision outranks run, run=0 outranks a tick.
  always_comb begin
    state_d  = state;
    tick_adv = 1'b0;
    spawn_go = 1'b0;
    go_idle  = 1'b0;
    case (state)
      IDLE:  if (run) state_d = WAIT;
      WAIT: begin
        if (collision) state_d = HALT;
        else if (!run) begin
          state_d = IDLE;
          go_idle = 1'b1;
        end else if (logic_tick) begin
          tick_adv = 1'b1;
          if (tick_cnt == interval - 16'd1) begin
            state_d  = SPAWN;
            spawn_go = 1'b1;
          end
        end
      end
      SPAWN: state_d = collision ? HALT : WAIT;
      HALT:  state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      enable      <= 1'b0;
      offset_x    <= 10'(LANE0_X);
      offset_y    <= 10'(SPAWN_Y);
      lane        <= 2'd0;
      spawn_total <= 8'd0;
      halted      <= 1'b0;
      tick_cnt    <= 16'd0;
      spawn_cnt   <= 8'd0;
      interval    <= 16'(SPAWN_INTERVAL);
      lfsr        <= SEED;
      first_spawn <= 1'b1;
    end else begin
      state  <= state_d;
      enable <= spawn_go;
      halted <= (state_d == HALT);
      if ((state == IDLE && run) || go_idle) tick_cnt <= 16'd0;
      if (tick_adv) begin
        lfsr     <= lfsr_nxt;
        tick_cnt <= spawn_go ? 16'd0 : tick_cnt + 16'd1;
      end
      if (spawn_go) begin
        lane        <= lane_sel;
        offset_x    <= 10'(LANE0_X + int'(lane_sel) * LANE_PITCH);
        offset_y    <= 10'(SPAWN_Y);
        first_spawn <= 1'b0;
        if (spawn_total != 8'hFF) spawn_total <= spawn_total + 8'd1;
        // Ramp: every RAMP_EVERY spawns shorten the interval, clamped at the floor.
        if (spawn_cnt + 8'd1 == 8'(RAMP_EVERY)) begin
          spawn_cnt <= 8'd0;
          if (interval >= 16'(MIN_INTERVAL + RAMP_STEP)) interval <= interval - 16'(RAMP_STEP);
          else                                           interval <= 16'(MIN_INTERVAL);
        end else begin
          spawn_cnt <= spawn_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_enemy_spawner.sv
// Randomized bench for enemy_spawner: a driver runs a behavioural game model and
// queues expected spawns; a monitor pops and compares whenever enable fires.
module tb_enemy_spawner;

  localparam int LC = 3, LX = 129, LP = 80, SY = 610;
  localparam int SI = 12, MI = 5, RE = 3, RS = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1, logic_tick = 1'b0, run = 1'b0, collision = 1'b0;
  logic       enable, halted;
  logic [9:0] offset_x, offset_y;
  logic [1:0] lane;
  logic [7:0] spawn_total;

  enemy_spawner #(.LANE_COUNT(LC), .LANE0_X(LX), .LANE_PITCH(LP), .SPAWN_Y(SY),
                  .SPAWN_INTERVAL(SI), .MIN_INTERVAL(MI), .RAMP_EVERY(RE),
                  .RAMP_STEP(RS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .logic_tick(logic_tick), .run(run),
    .collision(collision), .enable(enable), .offset_x(offset_x),
    .offset_y(offset_y), .lane(lane), .spawn_total(spawn_total), .halted(halted));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int lane; int ox; int tot;} exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  bit mon_en = 0;

  // Behavioural model state: waiting / spawning / halted flags, tick count,
  // total spawns since reset, LFSR value, last lane.
  bit          m_halt, m_active, m_spawn, m_first;
  int          m_ticks, m_nsp, m_lane;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Interval in force after n spawns: one RS reduction per RE spawns, floored at MI.
  function automatic int cur_interval();
    int v;
    v = SI - (m_nsp / RE) * RS;
    return (v < MI) ? MI : v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle of inputs and advance the model to the state after the next edge.
  task automatic step(input bit r, input bit rn, input bit tk, input bit co);
    int raw;
    exp_t e;
    @(negedge clk);
    reset = r; run = rn; logic_tick = tk; collision = co;
    if (r) begin
      m_halt = 0; m_active = 0; m_spawn = 0; m_first = 1;
      m_ticks = 0; m_nsp = 0; m_lane = 0; m_lfsr = SEED;
    end else if (m_halt) begin
      m_halt = 1;
    end else if (m_spawn) begin
      m_spawn = 0;
      if (co) m_halt = 1; else m_active = 1;
    end else if (!m_active) begin
      if (rn) begin m_active = 1; m_ticks = 0; end
    end else if (co) begin
      m_halt = 1; m_active = 0;
    end else if (!rn) begin
      m_active = 0; m_ticks = 0;
    end else if (tk) begin
      m_lfsr = lfsr_step(m_lfsr);
      m_ticks++;
      if (m_ticks == cur_interval()) begin
        raw = int'(m_lfsr[1:0]);
        if (raw >= LC) raw -= LC;
        if (!m_first && raw == m_lane) raw = (m_lane + 1) % LC;
        m_lane = raw; m_first = 0; m_nsp++;
        e.cyc = cyc + 1; e.lane = raw; e.ox = LX + raw * LP;
        e.tot = (m_nsp > 255) ? 255 : m_nsp;
        q.push_back(e);
        m_ticks = 0; m_active = 0; m_spawn = 1;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_enable"}, int'(enable), 0);
    chk({tag, "_halted"}, int'(halted), 0);
    chk({tag, "_offset_x"}, int'(offset_x), LX);
    chk({tag, "_offset_y"}, int'(offset_y), SY);
    chk({tag, "_lane"}, int'(lane), 0);
    chk({tag, "_spawn_total"}, int'(spawn_total), 0);
  endtask

  // Monitor: compares halted every cycle and each enable pulse against the queue.
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (mon_en) begin
      chk("halted", int'(halted), int'(m_halt));
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_spawn_cycle", cyc, e.cyc);
      end
      if (enable === 1'b1) begin
        if (q.size() == 0) chk("unexpected_spawn", 1, 0);
        else begin
          e = q.pop_front();
          chk("spawn_cycle", cyc, e.cyc);
          chk("lane", int'(lane), e.lane);
          chk("offset_x", int'(offset_x), e.ox);
          chk("offset_y", int'(offset_y), SY);
          chk("spawn_total", int'(spawn_total), e.tot);
        end
      end
    end
  end

  initial begin
    int guard, tot_before;
    // Power-on reset.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_reset("por");
    mon_en = 1;

    // Random play: occasional run drops (incl. run=0 with a tick), ticks ~50%.
    for (int i = 0; i < 1500; i++)
      step(0, $urandom_range(0, 24) != 0, $urandom_range(0, 1) == 1, 0);

    // Ticks every cycle until spawn_total has saturated.
    guard = 0;
    while (m_nsp < 262 && guard < 4000) begin
      step(0, 1, 1, 0);
      guard++;
    end
    if (guard >= 4000) chk("saturate_timeout", 1, 0);
    step(0, 1, 0, 0);
    chk("spawn_total_sat", int'(spawn_total), 255);

    // Collision on the tick that would complete the interval.
    guard = 0;
    while (!(m_active && m_ticks == cur_interval() - 1) && guard < 200) begin
      step(0, 1, $urandom_range(0, 1) == 1, 0);
      guard++;
    end
    if (guard >= 200) chk("collide_setup_timeout", 1, 0);
    tot_before = int'(spawn_total);
    step(0, 1, 1, 1);
    for (int i = 0; i < 60; i++) step(0, 1, 1, 0);
    chk("halt_flag", int'(halted), 1);
    chk("halt_total_kept", int'(spawn_total), tot_before);
    chk("halt_no_enable", int'(enable), 0);

    // Reset while halted.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_reset("rst_halt");

    // Run until a spawn is about to occur, then reset during SPAWN.
    guard = 0;
    while (!m_spawn && guard < 200) begin
      step(0, 1, 1, 0);
      guard++;
    end
    if (guard >= 200) chk("spawn_setup_timeout", 1, 0);
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    check_reset("rst_spawn");

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
